// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: column drive, row synchronizer,
// press/release debounce and single-key lockout. Outputs a hex key code,
// a one-cycle accept strobe and a held indication.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SCAN_W = $clog2(SCAN_CYCLES);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE_PRESS,
    HELD,
    DEBOUNCE_RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        rows_meta_q, rows_meta_d;
  logic [3:0]        rs_q, rs_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [1:0]        row_idx_q, row_idx_d;
  logic [3:0]        cols_q, cols_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;
  logic              row_low;

  // Physical key position {row, col} to the hex legend printed on the keypad.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Lowest-index low row wins when several rows are pulled down at once.
  function automatic logic [1:0] low_row(input logic [3:0] r);
    logic [1:0] idx;
    if (!r[0])      idx = 2'd0;
    else if (!r[1]) idx = 2'd1;
    else if (!r[2]) idx = 2'd2;
    else            idx = 2'd3;
    return idx;
  endfunction

  assign row_low   = ~rs_q[row_idx_q];
  assign cols      = cols_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

  // Next-state: scan rotation, debounce counting and output updates.
  always_comb begin
    state_d     = state_q;
    rows_meta_d = rows;
    rs_d        = rows_meta_q;
    scan_cnt_d  = scan_cnt_q;
    db_cnt_d    = db_cnt_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    case (state_q)
      SCAN: begin
        key_held_d = 1'b0;
        if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          if (rs_q != 4'hF) begin
            row_idx_d = low_row(rs_q);
            db_cnt_d  = '0;
            state_d   = DEBOUNCE_PRESS;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end
      DEBOUNCE_PRESS: begin
        if (row_low) begin
          if (db_cnt_q == DB_LAST) begin
            state_d     = HELD;
            db_cnt_d    = '0;
            key_code_d  = key_map(row_idx_q, col_idx_q);
            key_valid_d = 1'b1;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end else begin
          state_d    = SCAN;
          scan_cnt_d = '0;
          col_idx_d  = col_idx_q + 2'd1;
        end
      end
      HELD: begin
        key_held_d = 1'b1;
        if (!row_low) begin
          db_cnt_d = '0;
          state_d  = DEBOUNCE_RELEASE;
        end
      end
      default: begin
        if (!row_low) begin
          if (db_cnt_q == DB_LAST) begin
            state_d    = SCAN;
            scan_cnt_d = '0;
            col_idx_d  = col_idx_q + 2'd1;
            key_held_d = 1'b0;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end else begin
          db_cnt_d = '0;
          state_d  = HELD;
        end
      end
    endcase
    cols_d = ~(4'b0001 << col_idx_d);
  end

  // State and datapath registers; reset abandons any debounce in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SCAN;
      rows_meta_q <= 4'hF;
      rs_q        <= 4'hF;
      scan_cnt_q  <= '0;
      db_cnt_q    <= '0;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      cols_q      <= 4'b1110;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_meta_q <= rows_meta_d;
      rs_q        <= rs_d;
      scan_cnt_q  <= scan_cnt_d;
      db_cnt_q    <= db_cnt_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      cols_q      <= cols_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a behavioural keypad pulls rows low
// for any pressed key whose column is currently driven low.
module tb_keypad_scanner;

  localparam int SCAN_CYCLES     = 4;
  localparam int DEBOUNCE_CYCLES = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed = '0;   // bit r*4+c = key at row r, column c

  int errors = 0;
  int checks = 0;
  int vld_count = 0;
  int consec = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  // Keypad model: a pressed key connects its row to its column.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      rows[r] = ~|(pressed[r*4 +: 4] & ~cols);
  end

  keypad_scanner #(.SCAN_CYCLES(SCAN_CYCLES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) dut (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  // Count accepted keys and any back-to-back strobes.
  always @(posedge clk) begin
    if (key_valid) begin
      vld_count++;
      if (prev_valid) consec++;
    end
    prev_valid = key_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (key_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_release(input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (!key_held) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    tick(2);
    checks++; if (cols !== 4'b1110) begin errors++; $display("FAIL rst_cols: got %b expected 1110", cols); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL rst_code: got %h expected 0", key_code); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", key_valid); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rst_held: got %b expected 0", key_held); end
    reset = 1'b0;
    tick(3);
    checks++; if (cols !== 4'b1110) begin errors++; $display("FAIL scan_dwell0: got %b expected 1110", cols); end
    tick(1);
    checks++; if (cols !== 4'b1101) begin errors++; $display("FAIL scan_col1: got %b expected 1101", cols); end
    tick(4);
    checks++; if (cols !== 4'b1011) begin errors++; $display("FAIL scan_col2: got %b expected 1011", cols); end
    tick(4);
    checks++; if (cols !== 4'b0111) begin errors++; $display("FAIL scan_col3: got %b expected 0111", cols); end
    tick(4);
    checks++; if (cols !== 4'b1110) begin errors++; $display("FAIL scan_wrap: got %b expected 1110", cols); end
  endtask

  task automatic test_press_5;
    bit seen;
    int cyc;
    int v0;
    reset = 1'b1;
    tick(2);
    v0 = vld_count;
    pressed = 16'h0020;            // '5' = row1, col1
    reset = 1'b0;
    wait_valid(4*SCAN_CYCLES + 2 + DEBOUNCE_CYCLES + 2, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL p5_valid: got %b expected 1", seen); end
    checks++; if (key_code !== 4'h5) begin errors++; $display("FAIL p5_code: got %h expected 5", key_code); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL p5_held_early: got %b expected 0", key_held); end
    tick(1);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL p5_held: got %b expected 1", key_held); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL p5_strobe_len: got %b expected 0", key_valid); end
    pressed = '0;
    wait_release(40, cyc);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL p5_release: got held=%b expected 0", key_held); end
    checks++; if (vld_count !== v0 + 1) begin errors++; $display("FAIL p5_count: got %0d expected %0d", vld_count, v0 + 1); end
  endtask

  task automatic test_long_hold_d;
    bit seen;
    int cyc;
    int v0;
    v0 = vld_count;
    pressed = 16'h8000;            // 'D' = row3, col3
    wait_valid(60, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL pd_valid: got %b expected 1", seen); end
    checks++; if (key_code !== 4'hD) begin errors++; $display("FAIL pd_code: got %h expected D", key_code); end
    tick(500);
    checks++; if (vld_count !== v0 + 1) begin errors++; $display("FAIL pd_count: got %0d expected %0d", vld_count, v0 + 1); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL pd_held: got %b expected 1", key_held); end
    pressed = '0;
    wait_release(40, cyc);
    checks++; if (cyc < 16 || cyc > 20) begin errors++; $display("FAIL pd_release_lat: got %0d expected 16..20", cyc); end
    tick(10);
    checks++; if (key_code !== 4'hD) begin errors++; $display("FAIL pd_code_kept: got %h expected D", key_code); end
  endtask

  task automatic test_bounce_8;
    int v0;
    v0 = vld_count;
    for (int i = 0; i < 40; i++) begin
      pressed = ((i / 3) % 2 == 0) ? 16'h0200 : 16'h0000;   // '8' = row2, col1
      tick(1);
    end
    pressed = '0;
    tick(30);
    checks++; if (vld_count !== v0) begin errors++; $display("FAIL b8_count: got %0d expected %0d", vld_count, v0); end
    checks++; if (key_code !== 4'hD) begin errors++; $display("FAIL b8_code: got %h expected D", key_code); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL b8_held: got %b expected 0", key_held); end
  endtask

  task automatic test_priority_lockout;
    bit seen;
    int cyc;
    int v1;
    pressed = 16'h0808;            // 'A' (row0,col3) and 'C' (row2,col3)
    wait_valid(60, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL pa_valid: got %b expected 1", seen); end
    checks++; if (key_code !== 4'hA) begin errors++; $display("FAIL pa_code: got %h expected A", key_code); end
    tick(2);
    v1 = vld_count;
    pressed = pressed | 16'h0010;  // add '4' = row1, col0
    tick(60);
    checks++; if (vld_count !== v1) begin errors++; $display("FAIL pa_lockout: got %0d expected %0d", vld_count, v1); end
    checks++; if (key_code !== 4'hA) begin errors++; $display("FAIL pa_code_kept: got %h expected A", key_code); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL pa_held: got %b expected 1", key_held); end
    pressed = '0;
    wait_release(40, cyc);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL pa_release: got %b expected 0", key_held); end
  endtask

  task automatic test_release_bounce_0;
    bit seen;
    bit held_ok;
    int cyc;
    int v0;
    v0 = vld_count;
    pressed = 16'h2000;            // '0' = row3, col1
    wait_valid(60, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL p0_valid: got %b expected 1", seen); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL p0_code: got %h expected 0", key_code); end
    tick(20);
    held_ok = 1'b1;
    pressed = '0;
    for (int i = 0; i < 5; i++) begin tick(1); if (key_held !== 1'b1) held_ok = 1'b0; end
    pressed = 16'h2000;
    for (int i = 0; i < 2; i++) begin tick(1); if (key_held !== 1'b1) held_ok = 1'b0; end
    pressed = '0;
    wait_release(40, cyc);
    checks++; if (held_ok !== 1'b1) begin errors++; $display("FAIL p0_held_bounce: got %b expected 1", held_ok); end
    checks++; if (cyc < 16 || cyc > 20) begin errors++; $display("FAIL p0_release_lat: got %0d expected 16..20", cyc); end
    tick(2);
    checks++; if (vld_count !== v0 + 1) begin errors++; $display("FAIL p0_count: got %0d expected %0d", vld_count, v0 + 1); end
  endtask

  task automatic test_reset_mid_debounce;
    bit seen;
    int cyc;
    int v0;
    for (int i = 0; i < 20; i++) begin
      if (cols === 4'b1110) break;
      tick(1);
    end
    checks++; if (cols !== 4'b1110) begin errors++; $display("FAIL rf_find_col0: got %b expected 1110", cols); end
    v0 = vld_count;
    pressed = 16'h4000;            // 'F' = row3, col2
    for (int i = 0; i < 20; i++) begin
      if (cols === 4'b1011) break;
      tick(1);
    end
    checks++; if (cols !== 4'b1011) begin errors++; $display("FAIL rf_find_col2: got %b expected 1011", cols); end
    tick(SCAN_CYCLES + 8);
    checks++; if (cols !== 4'b1011) begin errors++; $display("FAIL rf_cols_frozen: got %b expected 1011", cols); end
    checks++; if (vld_count !== v0) begin errors++; $display("FAIL rf_early_valid: got %0d expected %0d", vld_count, v0); end
    reset = 1'b1;
    #1;
    checks++; if (cols !== 4'b1110) begin errors++; $display("FAIL rf_rst_cols: got %b expected 1110", cols); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rf_rst_valid: got %b expected 0", key_valid); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rf_rst_held: got %b expected 0", key_held); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL rf_rst_code: got %h expected 0", key_code); end
    tick(2);
    reset = 1'b0;
    wait_valid(60, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rf_valid: got %b expected 1", seen); end
    checks++; if (key_code !== 4'hF) begin errors++; $display("FAIL rf_code: got %h expected F", key_code); end
    tick(2);
    checks++; if (vld_count !== v0 + 1) begin errors++; $display("FAIL rf_count: got %0d expected %0d", vld_count, v0 + 1); end
    pressed = '0;
    wait_release(40, cyc);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rf_release: got %b expected 0", key_held); end
  endtask

  initial begin
    test_reset();
    test_press_5();
    test_long_hold_d();
    test_bounce_8();
    test_priority_lockout();
    test_release_bounce_0();
    test_reset_mid_debounce();
    checks++; if (consec !== 0) begin errors++; $display("FAIL valid_consecutive: got %0d expected 0", consec); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
